// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer
//   Multi-cycle controller that runs one MIPS R-type instruction at a time on
//   an external register-file/ALU datapath. It accepts an instruction, drives
//   the read addresses and function code (EXEC), captures the ALU result and
//   Zero flag, then writes the result back to rd with a one-cycle RegWrite
//   pulse (WB). A non-zero opcode takes the ERR path and pulses done+illegal.
//
//   Optional feature macro: RF_ALU_SEQ_R0_GUARD_EN
//     defined   -> a writeback to rd==0 is suppressed (RegWrite stays 0);
//                  done still pulses and result/zero_out still update.
//     undefined -> rd==0 is written like any other register.
//
// Ports
//   clock, reset_n           rising-edge clock, async active-low reset
//   instr_valid/instr        instruction offer and 32-bit word
//   instr_ready              high while IDLE
//   Read1/Read2/FuncCode     rs/rt/funct to the datapath (EXEC only, else 0)
//   ALUOp                    ALUOP_RTYPE in EXEC, else 0
//   ALUOut/Zero              datapath ALU result and zero flag
//   WriteReg/WriteData       rd and data for writeback (WB only, else 0)
//   RegWrite                 register-file write enable (WB only)
//   busy                     instruction in flight
//   done/illegal             completion pulse / illegal-opcode pulse
//   result/zero_out          last captured ALU result and Zero
module rf_alu_sequencer #(
  parameter int         REG_AW      = 6,
  parameter int         DATA_W      = 32,
  parameter logic [1:0] ALUOP_RTYPE = 2'b10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [REG_AW-1:0] Read1,
  output logic [REG_AW-1:0] Read2,
  output logic [5:0]        FuncCode,
  output logic [1:0]        ALUOp,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic              Zero,
  output logic [REG_AW-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] result,
  output logic              zero_out
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;

  state_t              state_q;
  logic [4:0]          rd_q;      // destination kept from the latched instruction
  logic [REG_AW-1:0]   rd1_q, rd2_q, wreg_q;
  logic [5:0]          func_q;
  logic [1:0]          aluop_q;
  logic [DATA_W-1:0]   wdata_q, result_q;
  logic                regwr_q, done_q, ill_q, rdy_q, busy_q, zero_q;

  // shamt is architecturally ignored by R-type ALU ops.
  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  function automatic logic [REG_AW-1:0] zx(input logic [4:0] f);
    zx      = '0;
    zx[4:0] = f;
  endfunction

  // All outputs are registered; each state's outputs are loaded on the edge
  // that enters it so they are valid for the whole cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      func_q   <= '0;
      aluop_q  <= '0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      regwr_q  <= 1'b0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            rd_q   <= instr[15:11];
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            if (instr[31:26] == 6'd0) begin
              state_q <= EXEC;
              rd1_q   <= zx(instr[25:21]);
              rd2_q   <= zx(instr[20:16]);
              func_q  <= instr[5:0];
              aluop_q <= ALUOP_RTYPE;
            end else begin
              state_q <= ERR;
              done_q  <= 1'b1;
              ill_q   <= 1'b1;
            end
          end
        end
        EXEC: begin
          state_q  <= WB;
          result_q <= ALUOut;
          zero_q   <= Zero;
          rd1_q    <= '0;
          rd2_q    <= '0;
          func_q   <= '0;
          aluop_q  <= '0;
          wreg_q   <= zx(rd_q);
          wdata_q  <= ALUOut;   // same value that lands in result
          done_q   <= 1'b1;
`ifdef RF_ALU_SEQ_R0_GUARD_EN
          regwr_q  <= (rd_q != 5'd0);
`else
          regwr_q  <= 1'b1;
`endif
        end
        WB, ERR: begin
          state_q <= IDLE;
          wreg_q  <= '0;
          wdata_q <= '0;
          regwr_q <= 1'b0;
          done_q  <= 1'b0;
          ill_q   <= 1'b0;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready = rdy_q;
  assign Read1       = rd1_q;
  assign Read2       = rd2_q;
  assign FuncCode    = func_q;
  assign ALUOp       = aluop_q;
  assign WriteReg    = wreg_q;
  assign WriteData   = wdata_q;
  assign RegWrite    = regwr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal     = ill_q;
  assign result      = result_q;
  assign zero_out    = zero_q;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Directed bench for rf_alu_sequencer with a small register-file/ALU model
// standing in for the datapath. Expected values are hand-computed constants.
module tb_rf_alu_sequencer;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic [31:0]   instr = '0;
  logic          instr_ready;
  logic [AW-1:0] Read1, Read2, WriteReg;
  logic [5:0]    FuncCode;
  logic [1:0]    ALUOp;
  logic [DW-1:0] ALUOut, WriteData, result;
  logic          Zero, RegWrite, busy, done, illegal, zero_out;

  rf_alu_sequencer #(.REG_AW(AW), .DATA_W(DW), .ALUOP_RTYPE(2'b10)) dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .Read1(Read1), .Read2(Read2), .FuncCode(FuncCode),
    .ALUOp(ALUOp), .ALUOut(ALUOut), .Zero(Zero), .WriteReg(WriteReg),
    .WriteData(WriteData), .RegWrite(RegWrite), .busy(busy), .done(done),
    .illegal(illegal), .result(result), .zero_out(zero_out)
  );

  always #5 clock = ~clock;

  // datapath model: register file + R-type ALU
  logic [DW-1:0] rf [0:63];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] a, b;

  always @(posedge clock) begin
    if (RegWrite)   rf[WriteReg] <= WriteData;
    else if (pl_en) rf[pl_addr]  <= pl_data;
  end

  always_comb begin
    a = rf[Read1];
    b = rf[Read2];
    case (FuncCode)
      6'h20:   ALUOut = a + b;
      6'h22:   ALUOut = a - b;
      6'h24:   ALUOut = a & b;
      6'h25:   ALUOut = a | b;
      6'h2a:   ALUOut = {31'd0, $signed(a) < $signed(b)};
      default: ALUOut = '0;
    endcase
    Zero = (ALUOut == '0);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic preload(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = ad; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // offer one instruction for a single edge; caller is in cycle 1 afterwards
  task automatic send(input string tag, input logic [31:0] w);
    chk({tag, "_rdy"}, instr_ready, 1'b1);
    instr_valid = 1'b1; instr = w;
    tick();
    instr_valid = 1'b0; instr = '0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_rdy",   instr_ready, 1'b1);
    chk("rst_busy",  busy,        1'b0);
    chk("rst_done",  done,        1'b0);
    chk("rst_rw",    RegWrite,    1'b0);
    chk("rst_r1",    Read1,       '0);
    chk("rst_aluop", ALUOp,       '0);
    chk("rst_wd",    WriteData,   '0);
    chk("rst_res",   result,      '0);
    chk("rst_zero",  zero_out,    1'b0);
    reset_n = 1'b1;
    tick();

    // add r3,r1,r2
    preload(1, 5); preload(2, 7); preload(3, 32'hdead);
    send("add", 32'h00221820);
    chk("add_c1_r1",   Read1,     1);
    chk("add_c1_r2",   Read2,     2);
    chk("add_c1_fn",   FuncCode,  6'h20);
    chk("add_c1_op",   ALUOp,     2'b10);
    chk("add_c1_busy", busy,      1'b1);
    chk("add_c1_rdy",  instr_ready, 1'b0);
    chk("add_c1_rw",   RegWrite,  1'b0);
    chk("add_c1_done", done,      1'b0);
    tick();
    chk("add_c2_rw",   RegWrite,  1'b1);
    chk("add_c2_wr",   WriteReg,  3);
    chk("add_c2_wd",   WriteData, 12);
    chk("add_c2_done", done,      1'b1);
    chk("add_c2_ill",  illegal,   1'b0);
    chk("add_c2_res",  result,    12);
    chk("add_c2_zero", zero_out,  1'b0);
    chk("add_c2_r1",   Read1,     0);
    tick();
    chk("add_r3",      rf[3],     12);
    chk("add_c3_rw",   RegWrite,  1'b0);
    chk("add_c3_done", done,      1'b0);
    chk("add_c3_rdy",  instr_ready, 1'b1);
    chk("add_c3_busy", busy,      1'b0);

    // illegal opcode 0x23
    send("ill", 32'h8C220000);
    chk("ill_c1_done", done,      1'b1);
    chk("ill_c1_ill",  illegal,   1'b1);
    chk("ill_c1_rw",   RegWrite,  1'b0);
    chk("ill_c1_rdy",  instr_ready, 1'b0);
    chk("ill_c1_busy", busy,      1'b1);
    chk("ill_c1_r1",   Read1,     0);
    chk("ill_c1_res",  result,    12);
    tick();
    chk("ill_c2_rdy",  instr_ready, 1'b1);
    chk("ill_c2_done", done,      1'b0);
    chk("ill_c2_ill",  illegal,   1'b0);
    chk("ill_c2_rw",   RegWrite,  1'b0);
    chk("ill_c2_res",  result,    12);

    // sub r4,r1,r1
    preload(1, 9); preload(4, 32'h55);
    send("sub", 32'h00212022);
    tick();
    chk("sub_c2_rw",   RegWrite,  1'b1);
    chk("sub_c2_wr",   WriteReg,  4);
    chk("sub_c2_wd",   WriteData, 0);
    chk("sub_c2_zero", zero_out,  1'b1);
    tick();
    chk("sub_r4",      rf[4],     0);

    // back-to-back: add r5,r1,r2 then sub r6,r5,r1 with valid held high
    preload(1, 5); preload(2, 7); preload(5, 0); preload(6, 0);
    instr_valid = 1'b1; instr = 32'h00222820;
    tick();
    instr = 32'h00A13022;
    chk("b2b_c1_r1",   Read1,     1);
    chk("b2b_c1_rdy",  instr_ready, 1'b0);
    tick();
    chk("b2b_c2_rdy",  instr_ready, 1'b0);
    chk("b2b_c2_wd",   WriteData, 12);
    tick();
    chk("b2b_c3_rdy",  instr_ready, 1'b1);
    chk("b2b_c3_r1",   Read1,     0);
    chk("b2b_r5",      rf[5],     12);
    tick();
    instr_valid = 1'b0; instr = '0;
    chk("b2b_c4_r1",   Read1,     5);
    chk("b2b_c4_r2",   Read2,     1);
    chk("b2b_c4_fn",   FuncCode,  6'h22);
    chk("b2b_c4_busy", busy,      1'b1);
    tick();
    chk("b2b_c5_wr",   WriteReg,  6);
    chk("b2b_c5_wd",   WriteData, 7);
    tick();
    chk("b2b_r6",      rf[6],     7);

    // reset asserted mid-WB
    preload(3, 32'haa);
    send("rwb", 32'h00221820);
    tick();
    chk("rwb_c2_rw",   RegWrite,  1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rwb_rw",      RegWrite,  1'b0);
    chk("rwb_rdy",     instr_ready, 1'b1);
    chk("rwb_busy",    busy,      1'b0);
    chk("rwb_done",    done,      1'b0);
    chk("rwb_wd",      WriteData, 0);
    tick();
    chk("rwb_r3",      rf[3],     32'haa);
    reset_n = 1'b1;
    tick();

    // add r0,r1,r2
    preload(0, 32'h33);
    send("r0", 32'h00220020);
    tick();
    chk("r0_c2_done",  done,      1'b1);
    chk("r0_c2_res",   result,    12);
`ifdef RF_ALU_SEQ_R0_GUARD_EN
    chk("r0_c2_rw",    RegWrite,  1'b0);
    tick();
    chk("r0_rf",       rf[0],     32'h33);
`else
    chk("r0_c2_rw",    RegWrite,  1'b1);
    chk("r0_c2_wr",    WriteReg,  0);
    tick();
    chk("r0_rf",       rf[0],     12);
`endif
    chk("r0_c3_rdy",   instr_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
